// File: rtl/idex_elastic_reg_if.sv
// rtl/idex_elastic_reg_if.sv - decode-side and execute-side handshake bundle for the ID/EX elastic register
interface idex_elastic_reg_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 11,
  parameter int FUNC_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [RA_W-1:0]   in_rs, in_rt, in_rd;
  logic [DATA_W-1:0] in_data1, in_data2, in_imm, in_next_pc, in_jump_addr;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [RA_W-1:0]   out_rs, out_rt, out_rd;
  logic [DATA_W-1:0] out_data1, out_data2, out_imm, out_next_pc, out_jump_addr;
  logic [CTRL_W-1:0] out_ctrl;
  logic [FUNC_W-1:0] out_func;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_data1, in_data2, in_imm, in_next_pc,
           in_jump_addr, in_ctrl, out_ready,
    input  in_ready, out_valid, out_rs, out_rt, out_rd, out_data1, out_data2, out_imm,
           out_next_pc, out_jump_addr, out_ctrl, out_func
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_data1, in_data2, in_imm, in_next_pc,
           in_jump_addr, in_ctrl, out_ready,
    output in_ready, out_valid, out_rs, out_rt, out_rd, out_data1, out_data2, out_imm,
           out_next_pc, out_jump_addr, out_ctrl, out_func
  );
endinterface

// File: rtl/idex_elastic_reg.sv
// rtl/idex_elastic_reg.sv - ID/EX pipeline register with 2-entry skid buffer and flush
// Optional saturating perf counters when IDEX_PERF_EN is defined.
module idex_elastic_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 11,
  parameter int FUNC_W = 6
`ifdef IDEX_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  idex_elastic_reg_if.slave  bus
`ifdef IDEX_PERF_EN
  , output logic [PERF_W-1:0] stall_cnt
  , output logic [PERF_W-1:0] bubble_cnt
  , output logic [PERF_W-1:0] flush_cnt
`endif
);
  localparam int PAY_W = 3*RA_W + 5*DATA_W + CTRL_W;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PAY_W-1:0]  main_q, main_d;
  logic [PAY_W-1:0]  skid_q, skid_d;
  logic [PAY_W-1:0]  in_pay;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_valid;
  logic              acc, ret;

  assign in_pay = {bus.in_rs, bus.in_rt, bus.in_rd, bus.in_data1, bus.in_data2, bus.in_imm,
                   bus.in_next_pc, bus.in_jump_addr, bus.in_ctrl};

  assign {bus.out_rs, bus.out_rt, bus.out_rd, bus.out_data1, bus.out_data2, bus.out_imm,
          bus.out_next_pc, bus.out_jump_addr, main_ctrl} = main_q;

  // in_ready is a pure decode of the state register, so out_ready never reaches it combinationally
  assign main_valid    = (state_q != EMPTY);
  assign bus.in_ready  = (state_q != SKID);
  assign bus.out_valid = main_valid;
  assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
  assign bus.out_func  = bus.out_imm[FUNC_W-1:0];

  assign acc = bus.in_valid & bus.in_ready;
  assign ret = main_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = in_pay;
          state_d = FULL;
        end
      end
      FULL: begin
        if (acc && ret) begin
          main_d = in_pay;
        end else if (acc) begin
          skid_d  = in_pay;
          state_d = SKID;
        end else if (ret) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (ret) begin
          main_d  = skid_q;
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Payload may still move on a flush; it is don't-care once both valids drop
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef IDEX_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (bus.in_valid && !bus.in_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (bus.out_ready && !main_valid && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + PERF_W'(1);
      if (flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif
endmodule
